aritmetica_serie: RTL and testbench

ARITMETICA_SERIE -- requirements
Module: aritmetica_serie

---
 rtl/aritmetica_serie.sv | 150 +++++++++++++++
 tb/tb_aritmetica_serie.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/aritmetica_serie.sv
// Chunk-serial adder/subtractor: WIDTH-bit operands processed CHUNK bits per cycle, LSB first.
// Subtraction support is compiled in only when ARIT_SUB_EN is defined; otherwise op is ignored.
module aritmetica_serie #(
    parameter int WIDTH = 12,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    input  logic             op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   resultado
);

    localparam int K  = WIDTH / CHUNK;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic             start_q;
    logic             trigger;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_d, done_d;
    logic [WIDTH:0]   res_d;
    logic [CHUNK-1:0] a_sl, b_sl, b_eff;
    logic [CHUNK:0]   part;
    logic             fin;
    int               base;

`ifdef ARIT_SUB_EN
    logic             op_q, op_d;
`else
    logic             unused_op;
    assign unused_op = op;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = busy;
        done_d  = done;
        res_d   = resultado;
`ifdef ARIT_SUB_EN
        op_d    = op_q;
`endif
        trigger = start & ~start_q;

        base  = int'(cnt_q) * CHUNK;
        a_sl  = a_q[base +: CHUNK];
        b_sl  = b_q[base +: CHUNK];
`ifdef ARIT_SUB_EN
        // Subtraction is A + ~B + 1; the +1 enters as the initial carry
        b_eff = op_q ? ~b_sl : b_sl;
`else
        b_eff = b_sl;
`endif
        part  = {1'b0, a_sl} + {1'b0, b_eff} + {{CHUNK{1'b0}}, carry_q};
`ifdef ARIT_SUB_EN
        fin   = op_q ? ~part[CHUNK] : part[CHUNK];
`else
        fin   = part[CHUNK];
`endif

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (trigger) begin
                    a_d     = num1;
                    b_d     = num2;
                    cnt_d   = '0;
`ifdef ARIT_SUB_EN
                    op_d    = op;
                    carry_d = op;
`else
                    carry_d = 1'b0;
`endif
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[base +: CHUNK] = part[CHUNK-1:0];
                carry_d = part[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    res_d   = {fin, sum_d};
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // start_q resets high so a start held across reset release is not an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            start_q   <= 1'b1;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            resultado <= '0;
`ifdef ARIT_SUB_EN
            op_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            busy      <= busy_d;
            done      <= done_d;
            resultado <= res_d;
`ifdef ARIT_SUB_EN
            op_q      <= op_d;
`endif
        end
    end

endmodule

// File: tb/tb_aritmetica_serie.sv
// Directed bench for aritmetica_serie (WIDTH=12, CHUNK=4); subtraction vectors follow ARIT_SUB_EN.
module tb_aritmetica_serie;

    logic        clk;
    logic        rst;
    logic [11:0] num1;
    logic [11:0] num2;
    logic        op;
    logic        start;
    logic        busy;
    logic        done;
    logic [12:0] resultado;

    int passes;
    int fails;
    int total;

    aritmetica_serie #(.WIDTH(12), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .num1      (num1),
        .num2      (num2),
        .op        (op),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .resultado (resultado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // pat[i] is the start level sampled at edge Ei; operands are scrambled after E0
    task automatic run_op(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input logic o, input logic [11:0] pat, input logic [12:0] exp);
        int nb;
        int nd;
        int dt;
        logic [12:0] got;
        nb = 0;
        nd = 0;
        dt = -1;
        got = '0;
        num1 = a;
        num2 = b;
        op = o;
        for (int i = 0; i < 12; i++) begin
            start = pat[i];
            if (i == 1) begin
                num1 = ~a;
                num2 = ~b;
                op = ~o;
            end
            tick();
            if (busy) nb++;
            if (done) begin
                nd++;
                if (dt < 0) dt = i;
                got = resultado;
            end
        end
        start = 1'b0;
        tick();
        tick();
        check({tag, " result"}, 32'(got), 32'(exp));
        check({tag, " busy_cycles"}, nb, 3);
        check({tag, " done_pulses"}, nd, 1);
        check({tag, " done_edge"}, dt, 3);
        check({tag, " held"}, 32'(resultado), 32'(exp));
    endtask

    initial begin
        int nb;
        int nd;
        passes = 0;
        fails = 0;
        total = 0;
        rst = 1'b0;
        start = 1'b0;
        num1 = '0;
        num2 = '0;
        op = 1'b0;
        tick();
        tick();
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset resultado", 32'(resultado), 0);
        #2 rst = 1'b1;
        tick();
        tick();
        check("idle busy", 32'(busy), 0);

        run_op("add_fff_001", 12'hFFF, 12'h001, 1'b0, 12'h001, 13'h1000);
        run_op("add_100_200", 12'd100, 12'd200, 1'b0, 12'h001, 13'h012C);
`ifdef ARIT_SUB_EN
        run_op("sub_5_7", 12'h005, 12'h007, 1'b1, 12'h001, 13'h1FFE);
        run_op("sub_7_5", 12'h007, 12'h005, 1'b1, 12'h001, 13'h0002);
        run_op("add_5_7", 12'h005, 12'h007, 1'b0, 12'h001, 13'h000C);
`else
        run_op("op1_as_add", 12'h005, 12'h007, 1'b1, 12'h001, 13'h000C);
`endif
        run_op("held_start", 12'h123, 12'h456, 1'b0, 12'h3FF, 13'h0579);
        run_op("retrigger", 12'hABC, 12'h111, 1'b0, 12'h015, 13'h0BCD);

        // Abort mid-operation, then hold start high through reset release
        num1 = 12'h0F0;
        num2 = 12'h00F;
        op = 1'b0;
        start = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
        check("abort resultado", 32'(resultado), 0);
        tick();
        tick();
        #3 rst = 1'b1;
        nb = 0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (busy) nb++;
            if (done) nd++;
        end
        check("post_reset busy", nb, 0);
        check("post_reset done", nd, 0);
        check("post_reset resultado", 32'(resultado), 0);
        start = 1'b0;
        tick();
        run_op("recover", 12'h001, 12'h002, 1'b0, 12'h001, 13'h0003);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
